// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// chunk sizing and the signed clamp limits used when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Limits come back 64 bits wide; callers truncate to their WIDTH (WIDTH <= 64).
  function automatic logic [63:0] signed_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe. The producer/consumer side
// uses the master modport, the arithmetic unit uses the slave modport.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             ctr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             sat;

  modport master (
    output in_valid, ctr, a, b, out_ready,
    input  in_ready, out_valid, out, carry, ovf, zero, sat
  );

  modport slave (
    input  in_valid, ctr, a, b, out_ready,
    output in_ready, out_valid, out, carry, ovf, zero, sat
  );
endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the pipelined carry chain: adds chunk IDX of the
// operands plus the incoming carry and registers the partial result.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             valid_in,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] res_in,
  output logic             valid_q,
  output logic             cout_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] res_q
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LSB   = IDX * CHUNK;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    // NOTE: res_d gets its full default before the chunk patch; a partial assignment would infer a latch.
    res_d = res_in;
    sum   = {1'b0, a_in[LSB +: CHUNK]} + {1'b0, b_in[LSB +: CHUNK]} + {{CHUNK{1'b0}}, cin};
    res_d[LSB +: CHUNK] = sum[CHUNK-1:0];
  end

  // NOTE: datapath flops are reset along with valid so every output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
      valid_q <= valid_in;
      cout_q  <= sum[CHUNK];
      a_q     <= a_in;
      b_q     <= b_in;
      res_q   <= res_d;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides and carry,
// overflow and zero flags. Define ADDSUB_SAT_EN to clamp signed overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  addsub_pipe_if.slave bus
);
  localparam int LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > 8) begin : g_bad_cfg
    $error("addsub_pipe: STAGES must be 1..8 and divide WIDTH");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] cout;
  logic [WIDTH-1:0]  opa [STAGES];
  logic [WIDTH-1:0]  opb [STAGES];
  logic [WIDTH-1:0]  res [STAGES];

  logic             cin0;
  logic [WIDTH-1:0] b0;

  // Subtract is a + ~b + 1: invert b once at the entry and seed the chain with 1.
  assign cin0 = (bus.ctr == OP_SUB);
  assign b0   = cin0 ? ~bus.b : bus.b;

  // Stage k may load whenever any stage from k to the end has a hole, or the
  // consumer drains the last stage; this is the ripple enable chain flattened.
  for (genvar k = 0; k < STAGES; k++) begin : g_ld
    assign ld[k] = bus.out_ready | ~(&vld[LAST:k]);
  end

  assign bus.in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;

    if (k == 0) begin : g_first
      assign v_in = bus.in_valid;
      assign c_in = cin0;
      assign a_in = bus.a;
      assign b_in = b0;
      assign r_in = '0;
    end else begin : g_next
      assign v_in = vld[k-1];
      assign c_in = cout[k-1];
      assign a_in = opa[k-1];
      assign b_in = opb[k-1];
      assign r_in = res[k-1];
    end

    addsub_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld[k]),
      .valid_in (v_in),
      .cin      (c_in),
      .a_in     (a_in),
      .b_in     (b_in),
      .res_in   (r_in),
      .valid_q  (vld[k]),
      .cout_q   (cout[k]),
      .a_q      (opa[k]),
      .b_q      (opb[k]),
      .res_q    (res[k])
    );
  end

  logic             vo;
  logic             s_a;
  logic             s_b;
  logic             ovf_c;
  logic             sat_c;
  logic [WIDTH-1:0] out_c;

  assign vo  = vld[LAST];
  assign s_a = opa[LAST][WIDTH-1];
  assign s_b = opb[LAST][WIDTH-1];

  // Flags are qualified by out_valid so an empty pipe never shows stale flags.
  assign ovf_c = vo & (s_a == s_b) & (res[LAST][WIDTH-1] != s_a);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));

  assign sat_c = ovf_c;
  assign out_c = ovf_c ? (s_a ? SMIN : SMAX) : res[LAST];
`else
  assign sat_c = 1'b0;
  assign out_c = res[LAST];
`endif

  assign bus.out_valid = vo;
  assign bus.out       = out_c;
  assign bus.carry     = vo & cout[LAST];
  assign bus.ovf       = ovf_c;
  assign bus.zero      = vo & (out_c == '0);
  assign bus.sat       = sat_c;

  // Only the sign bits of the final operand copies feed the flags.
  logic unused_ops;
  assign unused_ops = &{1'b0, opa[LAST][WIDTH-2:0], opb[LAST][WIDTH-2:0]};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed corner cases plus randomized
// traffic with random backpressure, scored against a signed-arithmetic model.
module tb_addsub_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  typedef logic [35:0] res_t;  // {out, carry, ovf, zero, sat}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

  addsub_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_push   = 0;
  res_t exp_q[$];
  bit   rand_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: exact signed/unsigned arithmetic on 64-bit integers.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    longint      sa, sb, sr;
    logic [31:0] o;
    logic        c, v, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = op ? (sa - sb) : (sa + sb);
    if (op) c = (a >= b);
    else    c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    o = sr[31:0];
    s = 1'b0;
`ifdef ADDSUB_SAT_EN
    if (v) begin
      s = 1'b1;
      o = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end
`endif
    return {o, c, v, (o == 32'd0), s};
  endfunction

  function automatic res_t dut_res();
    return {bus.out, bus.carry, bus.ovf, bus.zero, bus.sat};
  endfunction

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(7))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h0000_FFFF;
      5:       v = 32'h0001_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Scoreboard: sample between edges; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        check("scoreboard", dut_res(), exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.ctr));
        n_push++;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.ctr      = op;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("send_timeout", bus.in_ready, 1);
    sync();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input res_t exp);
    int cyc = 0;
    sync();
    bus.out_ready = 1'b1;
    send(a, b, op);
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 20);
    check({name, "_latency"}, cyc, STAGES);
    check(name, dut_res(), exp);
    sync();
  endtask

  task automatic drain();
    int w = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t held;
    int   acc0;
    int   w;

    bus.in_valid  = 1'b0;
    bus.ctr       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_outputs", dut_res(), 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);

    // Directed arithmetic corners
    run_one("add_5_3",     32'h0000_0005, 32'h0000_0003, 1'b0, {32'h0000_0008, 4'b0000});
    run_one("sub_to_zero", 32'h0001_0000, 32'h0001_0000, 1'b1, {32'h0000_0000, 4'b1010});
    run_one("chunk_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, {32'h0001_0000, 4'b0000});
    run_one("wrap_to_zero", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 4'b1010});
    run_one("borrow",      32'h0000_0000, 32'h0000_0001, 1'b1, {32'hFFFF_FFFF, 4'b0000});
`ifdef ADDSUB_SAT_EN
    run_one("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 4'b0101});
    run_one("neg_ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, {32'h8000_0000, 4'b1101});
    run_one("neg_ovf_add", 32'h8000_0000, 32'h8000_0000, 1'b0, {32'h8000_0000, 4'b1101});
`else
    run_one("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 4'b0100});
    run_one("neg_ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 4'b1100});
    run_one("neg_ovf_add", 32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 4'b1110});
`endif

    // Backpressure: six ops while the consumer stalls for four cycles
    acc0 = n_push;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_opnd(), rand_opnd(), 1'($urandom_range(1)));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (bus.in_ready && w < 10);
        check("bp_accepts_before_stall", n_push - acc0, STAGES);
        check("bp_valid_in_stall", bus.out_valid, 1);
        held = dut_res();
        @(negedge clk);
        check("bp_output_held", dut_res(), held);
        check("bp_in_ready_low", bus.in_ready, 0);
      end
    join
    drain();

    // Bubble collapse: op, gap, op with the consumer stalled
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    sync();
    send(32'h0000_0010, 32'h0000_0020, 1'b1);
    @(negedge clk);
    check("bubble_in_ready", bus.in_ready, 0);
    check("bubble_out_valid", bus.out_valid, 1);
    sync();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b_first", bus.out_valid, 1);
    @(negedge clk);
    check("b2b_second", bus.out_valid, 1);
    sync();
    drain();

    // Reset with two ops in flight
    bus.out_ready = 1'b1;
    send(32'h0000_0100, 32'h0000_0001, 1'b0);
    send(32'h0000_0200, 32'h0000_0002, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_flush_valid", bus.out_valid, 0);
    check("rst_flush_outputs", dut_res(), 0);
    exp_q.delete();
    sync();
    sync();
    rst_n = 1'b1;
    repeat (4) sync();
    check("no_stale_result", bus.out_valid, 0);
    run_one("after_reset", 32'h0000_0005, 32'h0000_0003, 1'b0, {32'h0000_0008, 4'b0000});

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) sync();
          send(rand_opnd(), rand_opnd(), 1'($urandom_range(1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          sync();
          bus.out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
